// File: rtl/load_store_unit.sv
// rtl/load_store_unit.sv - byte/halfword/word load-store unit with read-modify-write sub-word stores
// Single request in flight; sub-word stores merge into the current memory word before writing.
module load_store_unit #(
    parameter int MEM_BYTES = 1024
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_write,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        resp_valid,
    output logic [31:0] resp_rdata,
    output logic        resp_misaligned,
    output logic        resp_fault,
    output logic        mem_read,
    output logic        mem_write,
    output logic [31:0] mem_addr,
    output logic [31:0] mem_wd,
    input  logic [31:0] mem_rd
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        RMW_READ,
        WRITE,
        RESP
    } state_t;

    localparam logic [32:0] ADDR_LIMIT = 33'(MEM_BYTES);

    state_t      state_q, state_d;
    logic [31:0] addr_q, addr_d;
    logic [1:0]  size_q, size_d;
    logic        write_q, write_d;
    logic        unsigned_q, unsigned_d;
    logic [31:0] wdata_q, wdata_d;
    logic [31:0] rmw_q, rmw_d;
    logic        resp_valid_q, resp_valid_d;
    logic [31:0] resp_rdata_q, resp_rdata_d;
    logic        resp_mis_q, resp_mis_d;
    logic        resp_fault_q, resp_fault_d;

    logic        req_fault;
    logic        req_mis;
    logic [31:0] rd_shifted;
    logic [31:0] load_data;
    logic [31:0] store_word;

    assign req_fault = (req_size == 2'b11) || ({1'b0, req_addr} >= ADDR_LIMIT);
    assign req_mis   = ((req_size == 2'b01) && req_addr[0]) ||
                       ((req_size == 2'b10) && (req_addr[1:0] != 2'b00));

    // Bring the addressed lane down to bit 0, then extend to 32 bits.
    assign rd_shifted = mem_rd >> {addr_q[1:0], 3'b000};

    always_comb begin
        load_data = mem_rd;
        case (size_q)
            2'b00: load_data = unsigned_q ? {24'h0, rd_shifted[7:0]}
                                          : {{24{rd_shifted[7]}}, rd_shifted[7:0]};
            2'b01: load_data = unsigned_q ? {16'h0, rd_shifted[15:0]}
                                          : {{16{rd_shifted[15]}}, rd_shifted[15:0]};
            default: load_data = mem_rd;
        endcase
    end

    always_comb begin
        store_word = rmw_q;
        case (size_q)
            2'b00: store_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
            2'b01: store_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
            default: store_word = wdata_q;
        endcase
    end

    always_comb begin
        state_d      = state_q;
        addr_d       = addr_q;
        size_d       = size_q;
        write_d      = write_q;
        unsigned_d   = unsigned_q;
        wdata_d      = wdata_q;
        rmw_d        = rmw_q;
        resp_valid_d = 1'b0;
        resp_rdata_d = 32'h0;
        resp_mis_d   = 1'b0;
        resp_fault_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (req_valid) begin
                    addr_d     = req_addr;
                    size_d     = req_size;
                    write_d    = req_write;
                    unsigned_d = req_unsigned;
                    wdata_d    = req_wdata;
                    if (req_fault || req_mis) begin
                        state_d      = RESP;
                        resp_valid_d = 1'b1;
                        resp_fault_d = req_fault;
                        resp_mis_d   = req_mis && !req_fault;
                    end else if (!req_write) begin
                        state_d = LOAD;
                    end else if (req_size == 2'b10) begin
                        state_d = WRITE;
                    end else begin
                        state_d = RMW_READ;
                    end
                end
            end
            LOAD: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
                resp_rdata_d = load_data;
            end
            RMW_READ: begin
                state_d = WRITE;
                rmw_d   = mem_rd;
            end
            WRITE: begin
                state_d      = RESP;
                resp_valid_d = 1'b1;
            end
            RESP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q      <= IDLE;
            addr_q       <= 32'h0;
            size_q       <= 2'b00;
            write_q      <= 1'b0;
            unsigned_q   <= 1'b0;
            wdata_q      <= 32'h0;
            rmw_q        <= 32'h0;
            resp_valid_q <= 1'b0;
            resp_rdata_q <= 32'h0;
            resp_mis_q   <= 1'b0;
            resp_fault_q <= 1'b0;
        end else begin
            state_q      <= state_d;
            addr_q       <= addr_d;
            size_q       <= size_d;
            write_q      <= write_d;
            unsigned_q   <= unsigned_d;
            wdata_q      <= wdata_d;
            rmw_q        <= rmw_d;
            resp_valid_q <= resp_valid_d;
            resp_rdata_q <= resp_rdata_d;
            resp_mis_q   <= resp_mis_d;
            resp_fault_q <= resp_fault_d;
        end
    end

    // rst gates the handshake and the write strobe so nothing commits while reset is held.
    assign req_ready       = (state_q == IDLE) && !rst;
    assign mem_read        = (state_q == LOAD) || (state_q == RMW_READ);
    assign mem_write       = (state_q == WRITE) && !rst;
    assign mem_addr        = (state_q == LOAD || state_q == RMW_READ || state_q == WRITE)
                             ? {addr_q[31:2], 2'b00} : 32'h0;
    assign mem_wd          = (state_q == WRITE) ? store_word : 32'h0;
    assign resp_valid      = resp_valid_q;
    assign resp_rdata      = resp_rdata_q;
    assign resp_misaligned = resp_mis_q;
    assign resp_fault      = resp_fault_q;

    logic unused_write;
    assign unused_write = write_q;

endmodule

// File: tb/tb_load_store_unit.sv
// tb/tb_load_store_unit.sv - directed table, reset corner cases and randomized check of load_store_unit
module tb_load_store_unit;

    localparam int MEM_BYTES = 1024;

    logic        clk = 1'b0;
    logic        rst;
    logic        req_valid;
    logic        req_ready;
    logic        req_write;
    logic [1:0]  req_size;
    logic        req_unsigned;
    logic [31:0] req_addr;
    logic [31:0] req_wdata;
    logic        resp_valid;
    logic [31:0] resp_rdata;
    logic        resp_misaligned;
    logic        resp_fault;
    logic        mem_read;
    logic        mem_write;
    logic [31:0] mem_addr;
    logic [31:0] mem_wd;
    logic [31:0] mem_rd;

    load_store_unit #(.MEM_BYTES(MEM_BYTES)) dut (
        .clk(clk), .rst(rst),
        .req_valid(req_valid), .req_ready(req_ready), .req_write(req_write),
        .req_size(req_size), .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .resp_valid(resp_valid), .resp_rdata(resp_rdata),
        .resp_misaligned(resp_misaligned), .resp_fault(resp_fault),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wd(mem_wd), .mem_rd(mem_rd)
    );

    always #5 clk = ~clk;

    // Downstream memory seen by the DUT.
    logic [31:0] dmem [0:MEM_BYTES/4-1];
    assign mem_rd = dmem[mem_addr[9:2]];
    always @(posedge clk) if (mem_write) dmem[mem_addr[9:2]] <= mem_wd;

    // Reference memory, byte-granular.
    logic [7:0] ref_mem [0:MEM_BYTES-1];

    typedef struct {
        logic        w;
        logic [1:0]  sz;
        logic        u;
        logic [31:0] a;
        logic [31:0] wd;
        logic [31:0] e_rdata;
        logic        e_mis;
        logic        e_fault;
        int          e_lat;
        int          e_rd;
        int          e_wr;
        logic [31:0] e_mwd;
    } vec_t;

    typedef struct {
        logic        got;
        logic [31:0] rdata;
        logic        mis;
        logic        fault;
        int          lat;
        int          rd;
        int          wr;
        logic [31:0] mwd;
        int          waits;
    } obs_t;

    int tests = 0;
    int fails = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    function automatic vec_t model(input logic w, input logic [1:0] sz, input logic u,
                                   input logic [31:0] a, input logic [31:0] wd);
        vec_t e;
        int n;
        int base;
        logic [31:0] val;
        e = '{w: w, sz: sz, u: u, a: a, wd: wd, e_rdata: 0, e_mis: 0, e_fault: 0,
              e_lat: 1, e_rd: 0, e_wr: 0, e_mwd: 0};
        if (sz == 2'd3 || a >= MEM_BYTES) begin
            e.e_fault = 1'b1;
            return e;
        end
        n = 1 << sz;
        if (a % n != 0) begin
            e.e_mis = 1'b1;
            return e;
        end
        if (!w) begin
            val = 0;
            for (int i = 0; i < n; i++) val = val | (32'(ref_mem[int'(a) + i]) << (8 * i));
            if (!u && n < 4 && val[8 * n - 1]) val = val | (32'hFFFF_FFFF << (8 * n));
            e.e_rdata = val;
            e.e_lat = 2;
            e.e_rd = 1;
        end else begin
            for (int i = 0; i < n; i++) ref_mem[int'(a) + i] = wd[8 * i +: 8];
            base = int'(a) & ~3;
            e.e_mwd = {ref_mem[base + 3], ref_mem[base + 2], ref_mem[base + 1], ref_mem[base]};
            e.e_lat = (n == 4) ? 2 : 3;
            e.e_rd = (n == 4) ? 0 : 1;
            e.e_wr = 1;
        end
        return e;
    endfunction

    task automatic do_req(input vec_t v, output obs_t o);
        int guard;
        o = '{got: 0, rdata: 0, mis: 0, fault: 0, lat: 0, rd: 0, wr: 0, mwd: 0, waits: 0};
        req_valid = 1'b1;
        req_write = v.w;
        req_size = v.sz;
        req_unsigned = v.u;
        req_addr = v.a;
        req_wdata = v.wd;
        #1;
        guard = 0;
        while (!req_ready && guard < 20) begin
            @(negedge clk);
            guard++;
        end
        o.waits = guard;
        @(posedge clk);
        while (o.lat < 10 && !o.got) begin
            @(negedge clk);
            // Keep valid high with junk fields while busy: the DUT must ignore them.
            req_addr = $urandom;
            req_wdata = $urandom;
            req_write = 1'($urandom);
            req_size = 2'($urandom);
            req_unsigned = 1'($urandom);
            o.lat++;
            if (mem_read) o.rd++;
            if (mem_write) begin
                o.wr++;
                o.mwd = mem_wd;
            end
            if (resp_valid) begin
                o.got = 1'b1;
                o.rdata = resp_rdata;
                o.mis = resp_misaligned;
                o.fault = resp_fault;
                req_valid = 1'b0;
            end
        end
        req_valid = 1'b0;
    endtask

    task automatic compare(input string tag, input vec_t e, input obs_t o);
        chk({tag, " ready_gap"}, 32'(o.waits <= 1), 32'd1);
        chk({tag, " resp_seen"}, 32'(o.got), 32'd1);
        chk({tag, " latency"}, 32'(o.lat), 32'(e.e_lat));
        chk({tag, " rdata"}, o.rdata, e.e_rdata);
        chk({tag, " misaligned"}, 32'(o.mis), 32'(e.e_mis));
        chk({tag, " fault"}, 32'(o.fault), 32'(e.e_fault));
        chk({tag, " mem_read_cycles"}, 32'(o.rd), 32'(e.e_rd));
        chk({tag, " mem_write_cycles"}, 32'(o.wr), 32'(e.e_wr));
        if (e.e_wr > 0) chk({tag, " mem_wd"}, o.mwd, e.e_mwd);
    endtask

    initial begin
        vec_t vecs[$];
        vec_t e;
        obs_t o;
        int r;
        logic [1:0] sz;
        logic [31:0] a;

        for (int i = 0; i < MEM_BYTES / 4; i++) dmem[i] = 32'h0;
        for (int i = 0; i < MEM_BYTES; i++) ref_mem[i] = 8'h0;
        dmem[4] = 32'h8899AABB;
        dmem[8] = 32'h11223344;
        {ref_mem[8'h13], ref_mem[8'h12], ref_mem[8'h11], ref_mem[8'h10]} = 32'h8899AABB;
        {ref_mem[8'h23], ref_mem[8'h22], ref_mem[8'h21], ref_mem[8'h20]} = 32'h11223344;

        vecs.push_back('{0, 0, 0, 32'h12, 0, 32'hFFFFFF99, 0, 0, 2, 1, 0, 0});
        vecs.push_back('{0, 0, 1, 32'h12, 0, 32'h00000099, 0, 0, 2, 1, 0, 0});
        vecs.push_back('{1, 1, 0, 32'h22, 32'hBEEF, 0, 0, 0, 3, 1, 1, 32'hBEEF3344});
        vecs.push_back('{0, 2, 0, 32'h20, 0, 32'hBEEF3344, 0, 0, 2, 1, 0, 0});
        vecs.push_back('{0, 2, 0, 32'h06, 0, 0, 1, 0, 1, 0, 0, 0});
        vecs.push_back('{0, 2, 0, 32'h400, 0, 0, 0, 1, 1, 0, 0, 0});
        vecs.push_back('{0, 3, 0, 32'h0, 0, 0, 0, 1, 1, 0, 0, 0});
        vecs.push_back('{1, 2, 0, 32'h401, 32'h5, 0, 0, 1, 1, 0, 0, 0});
        vecs.push_back('{1, 2, 0, 32'h0, 32'hA5A50001, 0, 0, 0, 2, 0, 1, 32'hA5A50001});
        vecs.push_back('{1, 2, 0, 32'h4, 32'hA5A50002, 0, 0, 0, 2, 0, 1, 32'hA5A50002});
        vecs.push_back('{1, 2, 0, 32'h8, 32'hA5A50003, 0, 0, 0, 2, 0, 1, 32'hA5A50003});
        vecs.push_back('{1, 2, 0, 32'h3FC, 32'hDEADBEEF, 0, 0, 0, 2, 0, 1, 32'hDEADBEEF});
        vecs.push_back('{0, 2, 0, 32'h0, 0, 32'hA5A50001, 0, 0, 2, 1, 0, 0});
        vecs.push_back('{0, 2, 0, 32'h4, 0, 32'hA5A50002, 0, 0, 2, 1, 0, 0});
        vecs.push_back('{0, 2, 0, 32'h8, 0, 32'hA5A50003, 0, 0, 2, 1, 0, 0});
        vecs.push_back('{0, 2, 0, 32'h3FC, 0, 32'hDEADBEEF, 0, 0, 2, 1, 0, 0});
        vecs.push_back('{0, 1, 0, 32'h3FE, 0, 32'hFFFFDEAD, 0, 0, 2, 1, 0, 0});
        vecs.push_back('{0, 0, 1, 32'h3FF, 0, 32'h000000DE, 0, 0, 2, 1, 0, 0});
        vecs.push_back('{1, 0, 0, 32'h11, 32'h12345677, 0, 0, 0, 3, 1, 1, 32'h889977BB});
        vecs.push_back('{0, 1, 1, 32'h10, 0, 32'h000077BB, 0, 0, 2, 1, 0, 0});
        vecs.push_back('{1, 1, 0, 32'h13, 32'hFFFF, 0, 1, 0, 1, 0, 0, 0});

        rst = 1'b1;
        req_valid = 1'b0;
        req_write = 1'b0;
        req_size = 2'b00;
        req_unsigned = 1'b0;
        req_addr = 32'h0;
        req_wdata = 32'h0;
        repeat (3) @(negedge clk);
        chk("reset req_ready_low", 32'(req_ready), 32'd0);
        chk("reset mem_write_low", 32'(mem_write), 32'd0);
        chk("reset resp_valid", 32'(resp_valid), 32'd0);
        chk("reset resp_rdata", resp_rdata, 32'h0);
        chk("reset resp_flags", {30'h0, resp_misaligned, resp_fault}, 32'h0);
        rst = 1'b0;
        #1;
        chk("reset req_ready_after", 32'(req_ready), 32'd1);
        chk("reset mem_addr", mem_addr, 32'h0);

        foreach (vecs[i]) begin
            e = model(vecs[i].w, vecs[i].sz, vecs[i].u, vecs[i].a, vecs[i].wd);
            do_req(vecs[i], o);
            compare($sformatf("vec%0d", i), vecs[i], o);
        end

        // Reset pulsed while a byte store sits in WRITE.
        @(negedge clk);
        req_valid = 1'b1;
        req_write = 1'b1;
        req_size = 2'b00;
        req_unsigned = 1'b0;
        req_addr = 32'h31;
        req_wdata = 32'hFF;
        begin
            int guard = 0;
            #1;
            while (!req_ready && guard < 20) begin
                @(negedge clk);
                guard++;
            end
        end
        @(posedge clk);
        @(negedge clk);
        req_valid = 1'b0;
        chk("rstwr rmw_read", 32'(mem_read), 32'd1);
        @(negedge clk);
        chk("rstwr in_write", 32'(mem_write), 32'd1);
        rst = 1'b1;
        #1;
        chk("rstwr write_gated", 32'(mem_write), 32'd0);
        chk("rstwr ready_low", 32'(req_ready), 32'd0);
        @(negedge clk);
        rst = 1'b0;
        #1;
        chk("rstwr ready_after", 32'(req_ready), 32'd1);
        chk("rstwr no_resp", 32'(resp_valid), 32'd0);
        chk("rstwr mem_unchanged", dmem[12], 32'h0);
        @(negedge clk);
        chk("rstwr still_no_resp", 32'(resp_valid), 32'd0);
        e = model(1'b0, 2'b10, 1'b0, 32'h30, 32'h0);
        do_req(e, o);
        compare("rstwr load", e, o);

        for (int n = 0; n < 300; n++) begin
            r = $urandom_range(0, 99);
            sz = (r < 8) ? 2'd3 : 2'($urandom_range(0, 2));
            r = $urandom_range(0, 99);
            if (r < 6) a = 32'(MEM_BYTES) + $urandom_range(0, 64);
            else if (r < 9) a = $urandom;
            else a = $urandom_range(0, MEM_BYTES - 1);
            if ($urandom_range(0, 3) != 0 && sz != 2'd3) a = a & ~((32'd1 << sz) - 1);
            e = model(1'($urandom), sz, 1'($urandom), a, $urandom);
            do_req(e, o);
            compare($sformatf("rnd%0d", n), e, o);
        end

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule

// File: doc/load_store_unit.md
LOAD_STORE_UNIT -- requirements
Module: load_store_unit

Interface
REQ-001 The block SHALL have parameter MEM_BYTES, default 1024, giving the byte size of the downstream data memory; legal addresses are 0..MEM_BYTES-1.
REQ-002 The block SHALL have these ports:
- clk  in  1  single clock; all state updates on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  request accepted when req_valid and req_ready are both high at a rising edge
- req_write  in  1  1 = store, 0 = load
- req_size  in  2  00 byte, 01 halfword, 10 word, 11 illegal
- req_unsigned  in  1  loads: 1 = zero-extend, 0 = sign-extend
- req_addr  in  32  byte address
- req_wdata  in  32  store data, right-justified
- resp_valid  out  1  one-cycle completion pulse
- resp_rdata  out  32  load result, extended to 32 bits
- resp_misaligned  out  1  valid with resp_valid
- resp_fault  out  1  valid with resp_valid
- mem_read  out  1  drives the memory read enable
- mem_write  out  1  drives the memory write enable
- mem_addr  out  32  word-aligned memory address
- mem_wd  out  32  memory write data
- mem_rd  in  32  combinational memory read data, little-endian: byte at mem_addr+k = mem_rd[8k+7:8k]

Function
REQ-003 The FSM SHALL have states IDLE, LOAD, RMW_READ, WRITE and RESP; req_ready SHALL be 1 only in IDLE.
REQ-004 On acceptance, addr, size, write, unsigned and wdata SHALL be latched; the block SHALL ignore request inputs outside IDLE.
REQ-005 Fault SHALL be flagged when req_size = 11 or req_addr >= MEM_BYTES; fault takes priority over misalignment.
REQ-006 Misalignment SHALL be flagged for halfword with addr[0]=1 or word with addr[1:0]!=00.
REQ-007 A faulted or misaligned request SHALL transition IDLE->RESP with no memory access, and resp_rdata = 0.
REQ-008 An aligned load SHALL transition IDLE->LOAD->RESP.
REQ-009 An aligned word store SHALL transition IDLE->WRITE->RESP.
REQ-010 An aligned byte or halfword store SHALL transition IDLE->RMW_READ->WRITE->RESP.
REQ-011 mem_addr SHALL be {addr[31:2],2'b00} in LOAD, RMW_READ and WRITE, and 0 otherwise.
REQ-012 mem_read SHALL be 1 only in LOAD and RMW_READ.
REQ-013 mem_write SHALL be 1 only in WRITE with rst low.
REQ-014 In LOAD, the block SHALL select the byte or halfword at offset addr[1:0] from mem_rd, extend it per req_unsigned, and register it into resp_rdata at the LOAD->RESP edge; word loads SHALL pass mem_rd unchanged.
REQ-015 In RMW_READ, the block SHALL register mem_rd.
REQ-016 In WRITE, mem_wd SHALL equal the registered word with only the addressed byte or halfword replaced by wdata[7:0] or wdata[15:0]; for word stores, mem_wd SHALL equal wdata.
REQ-017 resp_valid SHALL be 1 only in RESP, for exactly one cycle, followed by IDLE; store responses SHALL leave resp_rdata = 0.
REQ-018 Latency from the acceptance edge to resp_valid SHALL be 2 cycles for loads and word stores, 3 cycles for sub-word stores, and 1 cycle for faulted or misaligned requests.
REQ-019 Back-to-back requests SHALL be possible: a new request may be accepted in the IDLE cycle that follows RESP.

Reset
REQ-020 With rst high at a rising edge, the state SHALL become IDLE and resp_valid, resp_rdata, resp_misaligned, resp_fault, and all latched request fields SHALL become 0.
REQ-021 Reset asserted in any state, including mid-RMW, SHALL abort the operation with no response; no memory write SHALL commit in a cycle where rst is high.
REQ-022 req_ready SHALL be 0 while rst is high and SHALL become 1 in the first cycle after reset deasserts.

Verification
REQ-023 Memory word 0x10 = 0x8899AABB; byte load at 0x12 with unsigned=0 -> resp 2 cycles after acceptance, resp_rdata = 0xFFFFFF99; with unsigned=1 -> resp_rdata = 0x00000099.
REQ-024 Memory word 0x20 = 0x11223344; halfword store of 0xBEEF at 0x22 -> mem_read seen for 1 cycle, then mem_write with mem_wd = 0xBEEF3344, resp 3 cycles after acceptance; a subsequent word load at 0x20 -> 0xBEEF3344.
REQ-025 Word load at 0x06 -> resp 1 cycle after acceptance, resp_misaligned=1, mem_read/mem_write never asserted; word load at 0x400 (MEM_BYTES=1024) -> resp_fault=1, resp_misaligned=0.
REQ-026 Sub-word store with rst pulsed during WRITE -> no resp_valid, memory word unchanged, req_ready=1 in the first cycle after rst deasserts.
REQ-027 Four back-to-back word stores followed by loads to 0x0, 0x4, 0x8 and 0x3FC -> every response arrives at the REQ-018 latency and all read data matches the stored data.
